// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// State encoding, frame geometry and default bit period.
package fifo_uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while en is high.
// Ports: clk, reset (sync, high), clear, en in; tick out on last count.
module baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and sends each byte as an 8N1 UART frame.
// Ports: clk, reset, enable, fifo_empty, fifo_dout in;
//        fifo_rden, tx, busy, tx_done out.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rden,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  state_t     state;
  state_t     state_n;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic [2:0] bit_idx_n;
  logic       tx_n;
  logic       on_line;
  logic       tick;

  // The counter only runs while a bit is on the line, so it is
  // already zero when START is entered from LOAD.
  assign on_line = (state == S_START) ||
                   (state == S_DATA)  ||
                   (state == S_STOP);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(!on_line),
    .en   (on_line),
    .tick (tick)
  );

  assign fifo_rden = (state == S_FETCH);
  assign busy      = (state != S_IDLE);
  assign tx_done   = (state == S_STOP) && tick;

  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    unique case (state)
      S_IDLE: begin
        if (enable && !fifo_empty) state_n = S_FETCH;
      end
      S_FETCH: state_n = S_LOAD;
      S_LOAD:  state_n = S_START;
      S_START: begin
        if (tick) begin
          state_n   = S_DATA;
          bit_idx_n = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx == 3'(DATA_BITS - 1)) state_n = S_STOP;
          else bit_idx_n = bit_idx + 1'b1;
        end
      end
      S_STOP: begin
        if (tick) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // tx is registered from the next state so the line level lines
  // up with the state register cycle for cycle.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      tx      <= tx_n;
      bit_idx <= bit_idx_n;
      if (state == S_LOAD) shift <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx with a 1-cycle-latency FIFO model.
// Monitor decodes tx frames and compares against queued bytes.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int CPB  = 4;
  localparam int FLEN = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty;
  logic       fifo_rden;
  logic       tx;
  logic       busy;
  logic       tx_done;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rden (fifo_rden),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] rd = 8'd0;
  logic [7:0] wr = 8'd0;

  assign fifo_empty = (rd == wr);

  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_dout <= mem[rd];
      rd <= rd + 8'd1;
    end
  end

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  logic [7:0] exp_q [$];
  int gaps [$];
  int mcyc = 0;
  int rden_cnt = 0;
  int last_rden = -100;
  int last_start = 0;
  int last_end = 0;
  int frame_k = -1;
  bit in_frame = 1'b0;
  bit prev_rden = 1'b0;
  bit end_valid = 1'b0;

  task automatic tick_mon();
    mcyc++;
    if (fifo_rden === 1'b1) begin
      rden_cnt++;
      chk("rden_pulse", int'(prev_rden), 0);
      chk("rden_nonempty", int'(rd == wr), 0);
      last_rden = mcyc;
    end
    prev_rden = (fifo_rden === 1'b1);
  endtask

  initial begin : monitor
    logic [FLEN-1:0] got;
    logic [FLEN-1:0] want;
    logic [7:0] b;
    int dcnt;
    int dpos;
    bit bad_busy;
    bit aborted;
    forever begin
      @(negedge clk);
      tick_mon();
      if (reset === 1'b0 && tx === 1'b0) begin
        in_frame = 1'b1;
        last_start = mcyc;
        chk("tx_latency", mcyc - last_rden, 2);
        if (end_valid) gaps.push_back(mcyc - last_end - 1);
        got = '0;
        got[0] = tx;
        bad_busy = (busy !== 1'b1);
        dcnt = 0;
        dpos = -1;
        aborted = 1'b0;
        frame_k = 0;
        if (tx_done === 1'b1) begin
          dcnt++;
          dpos = 0;
        end
        for (int k = 1; k < FLEN; k++) begin
          @(negedge clk);
          tick_mon();
          if (reset !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          got[k] = tx;
          frame_k = k;
          if (busy !== 1'b1) bad_busy = 1'b1;
          if (tx_done === 1'b1) begin
            dcnt++;
            dpos = k;
          end
        end
        in_frame = 1'b0;
        frame_k = -1;
        if (aborted) begin
          end_valid = 1'b0;
        end else begin
          last_end = mcyc;
          end_valid = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            b = exp_q.pop_front();
            for (int j = 0; j < FRAME_BITS; j++)
              for (int c = 0; c < CPB; c++)
                want[j*CPB+c] = (j == 0) ? 1'b0 :
                  (j == FRAME_BITS - 1) ? 1'b1 : b[j-1];
            checks++;
            if (got !== want) begin
              failures++;
              $display("FAIL frame %h: got %h expected %h",
                       b, got, want);
            end
            chk("frame_busy", int'(bad_busy), 0);
            chk("tx_done_count", dcnt, 1);
            chk("tx_done_pos", dpos, FLEN - 1);
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] v, input bit expect_it);
    mem[wr] = v;
    wr = wr + 8'd1;
    if (expect_it) exp_q.push_back(v);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(exp_q.size() == 0 && busy === 1'b0) && n < 3000);
    chk({name, "_timeout"}, int'(n >= 3000), 0);
  endtask

  task automatic wait_k(input int k, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(in_frame && frame_k == k) && n < 3000);
    chk({name, "_reach"}, int'(n >= 3000), 0);
  endtask

  initial begin : stim
    int base;
    int ok;
    int e;
    reset = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rden", int'(fifo_rden), 0);
    end
    cyc(1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_tx", int'(tx), 1);
      chk("idle_busy", int'(busy), 0);
      chk("idle_rden", int'(fifo_rden), 0);
    end

    // single byte
    cyc(1);
    push(8'hA5, 1'b1);
    base = rden_cnt;
    enable = 1'b1;
    wait_idle("t1");
    chk("t1_rden", rden_cnt - base, 1);

    // back-to-back
    cyc(1);
    enable = 1'b0;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    gaps.delete();
    base = rden_cnt;
    enable = 1'b1;
    wait_idle("t2");
    chk("t2_rden", rden_cnt - base, 2);
    chk("t2_gaps", gaps.size(), 2);
    chk("t2_gap",
        (gaps.size() > 0) ? gaps[gaps.size()-1] : -1, 3);
    chk("t2_empty", int'(fifo_empty), 1);

    // enable gating
    cyc(1);
    enable = 1'b0;
    push(8'h3C, 1'b1);
    base = rden_cnt;
    ok = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx === 1'b1 && fifo_rden === 1'b0 && busy === 1'b0)
        ok++;
    end
    chk("t3_hold", ok, 50);
    chk("t3_rden", rden_cnt - base, 0);
    cyc(1);
    enable = 1'b1;
    @(negedge clk);
    #1;
    e = mcyc;
    wait_idle("t3");
    chk("t3_start", last_start - e, 3);

    // enable drop mid-frame
    cyc(1);
    enable = 1'b0;
    push(8'h5A, 1'b1);
    push(8'h81, 1'b0);
    push(8'h3C, 1'b0);
    base = rden_cnt;
    enable = 1'b1;
    wait_k(4*CPB + 1, "t4");
    enable = 1'b0;
    wait_idle("t4");
    repeat (20) @(negedge clk);
    chk("t4_rden", rden_cnt - base, 1);
    chk("t4_left", int'(8'(wr - rd)), 2);
    chk("t4_tx", int'(tx), 1);

    // reset mid-frame during 0x81, then 0x3C goes out
    cyc(1);
    exp_q.push_back(8'h3C);
    base = rden_cnt;
    enable = 1'b1;
    wait_k(6*CPB + 1, "t5");
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rst_tx", int'(tx), 1);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_rden", int'(fifo_rden), 0);
    cyc(1);
    reset = 1'b0;
    wait_idle("t5");
    chk("t5_rden", rden_cnt - base, 2);
    chk("t5_empty", int'(fifo_empty), 1);
    chk("t5_dataw", DATA_BITS, 8);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
